// File: rtl/input_port_bank.sv
// Parametrised input-port bank.
// External ports pass through synchronisers. One port is registered onto the read bus.
// Each port has a sticky "changed" flag. One port drives masked rising-edge interrupt logic.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   in_ports     NPORTS*WIDTH asynchronous inputs, port i = in_ports[i*WIDTH +: WIDTH]
//   sel_port     port routed onto out (out = 0 when sel_port >= NPORTS)
//   rd_clr       clear the changed flag of port sel_port
//   irq_mask     per-bit rising-edge interrupt enable for port IRQ_PORT
//   irq_ack      clear every irq_cause bit
//   out          registered value of the selected synchronised port
//   port_changed sticky per-port change flags
//   irq_cause    sticky masked rising edges seen on IRQ_PORT
//   interrupt    OR of irq_cause
module input_port_bank #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NPORTS      = 4,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned IRQ_PORT    = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS*WIDTH-1:0]  in_ports,
    input  logic [SEL_W-1:0]         sel_port,
    input  logic                     rd_clr,
    input  logic [WIDTH-1:0]         irq_mask,
    input  logic                     irq_ack,
    output logic [WIDTH-1:0]         out,
    output logic [NPORTS-1:0]        port_changed,
    output logic [WIDTH-1:0]         irq_cause,
    output logic                     interrupt
);

    localparam int unsigned BUS_W   = NPORTS * WIDTH;
    localparam int unsigned CHAIN_W = SYNC_STAGES * BUS_W;
    localparam int unsigned IRQ_LSB = IRQ_PORT * WIDTH;

    logic [CHAIN_W-1:0] sync_chain;
    logic [BUS_W-1:0]   sync_bus;
    logic [BUS_W-1:0]   prev_bus;
    logic [WIDTH-1:0]   out_next;
    logic [NPORTS-1:0]  changed_next;
    logic [WIDTH-1:0]   irq_sync;
    logic [WIDTH-1:0]   irq_prev;
    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   cause_next;

    // Oldest stage of the chain sits in the top BUS_W bits.
    assign sync_bus = sync_chain[CHAIN_W-1 -: BUS_W];

    // Synchroniser chain shifts upward; the cast drops the stage that falls off the top.
    always_ff @(posedge clk) begin : sync_regs
        if (!reset) begin
            sync_chain <= '0;
            prev_bus   <= '0;
        end else begin
            sync_chain <= CHAIN_W'({sync_chain, in_ports});
            prev_bus   <= sync_bus;
        end
    end

    // Read mux and changed-flag update; a fresh diff beats a coincident clear.
    always_comb begin : port_next
        out_next     = '0;
        changed_next = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (sel_port == SEL_W'(i)) begin
                out_next = sync_bus[i*WIDTH +: WIDTH];
            end
            changed_next[i] = (sync_bus[i*WIDTH +: WIDTH] != prev_bus[i*WIDTH +: WIDTH])
                            | (port_changed[i] & ~(rd_clr & (sel_port == SEL_W'(i))));
        end
    end

    // Rising edges on the interrupt port survive a coincident acknowledge.
    assign irq_sync   = sync_bus[IRQ_LSB +: WIDTH];
    assign irq_prev   = prev_bus[IRQ_LSB +: WIDTH];
    assign rise       = irq_sync & ~irq_prev & irq_mask;
    assign cause_next = rise | (irq_ack ? '0 : irq_cause);

    // Output registers.
    always_ff @(posedge clk) begin : out_regs
        if (!reset) begin
            out          <= '0;
            port_changed <= '0;
            irq_cause    <= '0;
        end else begin
            out          <= out_next;
            port_changed <= changed_next;
            irq_cause    <= cause_next;
        end
    end

    assign interrupt = |irq_cause;

endmodule

// File: tb/tb_input_port_bank.sv
// Bench for input_port_bank: directed scenarios then random traffic, scored against a
// delay-line reference model through an expectation queue drained by a monitor.
module tb_input_port_bank;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NPORTS = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned IRQP   = 0;
    localparam int unsigned S      = 2;
    localparam int unsigned BUS_W  = NPORTS * WIDTH;

    logic               clk = 1'b0;
    logic               reset;
    logic [BUS_W-1:0]   in_ports;
    logic [SEL_W-1:0]   sel_port;
    logic               rd_clr;
    logic [WIDTH-1:0]   irq_mask;
    logic               irq_ack;
    logic [WIDTH-1:0]   out;
    logic [NPORTS-1:0]  port_changed;
    logic [WIDTH-1:0]   irq_cause;
    logic               interrupt;

    input_port_bank #(
        .WIDTH(WIDTH), .NPORTS(NPORTS), .SEL_W(SEL_W), .IRQ_PORT(IRQP), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .in_ports(in_ports), .sel_port(sel_port),
        .rd_clr(rd_clr), .irq_mask(irq_mask), .irq_ack(irq_ack), .out(out),
        .port_changed(port_changed), .irq_cause(irq_cause), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0]  out;
        logic [NPORTS-1:0] changed;
        logic [WIDTH-1:0]  cause;
        logic              intr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: hist[k][p] is port p as captured k edges ago (k=0 newest).
    logic [WIDTH-1:0]  hist [0:S][0:NPORTS-1];
    logic [NPORTS-1:0] m_changed;
    logic [WIDTH-1:0]  m_cause;
    logic [WIDTH-1:0]  m_out;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Predict the outputs after the coming clock edge from the inputs now driven.
    task automatic model_edge();
        exp_t             e;
        logic [WIDTH-1:0] s_v;
        logic [WIDTH-1:0] p_v;
        int unsigned      sel;
        if (!reset) begin
            for (int k = 0; k <= S; k++)
                for (int p = 0; p < NPORTS; p++) hist[k][p] = '0;
            m_changed = '0;
            m_cause   = '0;
            m_out     = '0;
        end else begin
            sel = 32'(sel_port);
            for (int p = 0; p < NPORTS; p++) begin
                s_v = hist[S-1][p];
                p_v = hist[S][p];
                if (s_v != p_v)                               m_changed[p] = 1'b1;
                else if (rd_clr && sel == 32'(p))             m_changed[p] = 1'b0;
            end
            s_v = hist[S-1][IRQP];
            p_v = hist[S][IRQP];
            m_cause = (s_v & ~p_v & irq_mask) | (irq_ack ? '0 : m_cause);
            m_out   = (sel < NPORTS) ? hist[S-1][sel] : '0;
            for (int k = S; k >= 1; k--)
                for (int p = 0; p < NPORTS; p++) hist[k][p] = hist[k-1][p];
            for (int p = 0; p < NPORTS; p++) hist[0][p] = in_ports[p*WIDTH +: WIDTH];
        end
        e.out     = m_out;
        e.changed = m_changed;
        e.cause   = m_cause;
        e.intr    = |m_cause;
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out",          32'(out),          32'(e.out));
            chk("port_changed", 32'(port_changed), 32'(e.changed));
            chk("irq_cause",    32'(irq_cause),    32'(e.cause));
            chk("interrupt",    32'(interrupt),    32'(e.intr));
        end
    end

    initial begin
        reset = 1'b0; in_ports = '1; sel_port = '0; rd_clr = 1'b0;
        irq_mask = '0; irq_ack = 1'b0;

        // Reset held with all inputs high.
        for (int n = 0; n < 3; n++) begin
            step();
            chk("rst_out",  32'(out),          32'h0);
            chk("rst_chg",  32'(port_changed), 32'h0);
            chk("rst_irq",  32'(interrupt),    32'h0);
        end

        // Clean start from all-zero inputs.
        in_ports = '0;
        step();
        reset = 1'b1;
        for (int n = 0; n < 4; n++) step();

        // Latency: port2 -> 0xA5, port3 -> 0x3C before E0, visible after E0+2.
        sel_port = 3'd2;
        in_ports[2*WIDTH +: WIDTH] = 8'hA5;
        in_ports[3*WIDTH +: WIDTH] = 8'h3C;
        step();
        step();
        chk("lat_out_early", 32'(out), 32'h0);
        step();
        chk("lat_out",  32'(out),          32'hA5);
        chk("lat_chg",  32'(port_changed), 32'hC);
        rd_clr = 1'b1;
        step();
        rd_clr = 1'b0;
        chk("rdclr_only2", 32'(port_changed), 32'h8);

        // Interrupt on port0 bit0.
        irq_mask = 8'h01;
        in_ports[0 +: WIDTH] = 8'h01;
        step();
        step();
        chk("irq_early", 32'(interrupt), 32'h0);
        step();
        chk("irq_cause", 32'(irq_cause), 32'h01);
        chk("irq_high",  32'(interrupt), 32'h1);
        in_ports[0 +: WIDTH] = 8'h03;
        for (int n = 0; n < 4; n++) step();
        chk("irq_masked_bit1", 32'(irq_cause), 32'h01);

        // Ack race: bit1 rise meets irq_ack at the same edge.
        irq_mask = 8'h03;
        in_ports[0 +: WIDTH] = 8'h01;
        for (int n = 0; n < 3; n++) step();
        chk("irq_fall_hold", 32'(irq_cause), 32'h01);
        in_ports[0 +: WIDTH] = 8'h03;
        step();
        step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("ack_race_cause", 32'(irq_cause), 32'h02);
        chk("ack_race_irq",   32'(interrupt), 32'h1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("ack_clear", 32'(interrupt), 32'h0);

        // Set-vs-clear race on port1.
        sel_port = 3'd1;
        in_ports[1*WIDTH +: WIDTH] = 8'h11;
        for (int n = 0; n < 3; n++) step();
        in_ports[1*WIDTH +: WIDTH] = 8'h22;
        step();
        step();
        rd_clr = 1'b1;
        step();
        rd_clr = 1'b0;
        chk("set_wins", 32'(port_changed[1]), 32'h1);
        step();
        rd_clr = 1'b1;
        step();
        rd_clr = 1'b0;
        chk("clr_port1", 32'(port_changed[1]), 32'h0);
        sel_port = 3'd5;
        step();
        chk("sel_oob", 32'(out), 32'h0);

        // Random traffic with occasional mid-run resets.
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 2) == 0) in_ports = in_ports ^ BUS_W'($urandom & $urandom);
            sel_port = SEL_W'($urandom_range(0, 7));
            rd_clr   = ($urandom_range(0, 2) == 0);
            irq_mask = WIDTH'($urandom);
            irq_ack  = ($urandom_range(0, 4) == 0);
            step();
        end
        reset = 1'b1; rd_clr = 1'b0; irq_ack = 1'b0;

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
